seq_mult_unit: RTL

Parametrised multiply datapath with an integrated controller. It holds the M (multiplicand), Q (multiplier/counter) and R (accumulator) registers, an adder and Q zero detection. A built-in FSM sequences the multiply from a start/done handshake, so the unit no longer needs a per-cycle external control word. Runtime-selectable algorithm: repeated addition (Q iterations) or shift-add (WIDTH iterations). The accumulator is double width.

---
 rtl/seq_mult_pkg.sv | 13 +
 rtl/gp_reg_n.sv | 31 +++
 rtl/seq_mult_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiply unit.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_REPADD   = 1'b0;
    localparam logic MODE_SHIFTADD = 1'b1;

endpackage

// File: rtl/gp_reg_n.sv
// General-purpose W-bit register with clear, parallel load and decrement.
module gp_reg_n #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic         dec,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Priority: reset, then clear, then load, then decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clear) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end else if (dec) begin
            q_q <= q_q - W'(1);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_mult_unit.sv
// Multiply datapath (M, Q, R) with an integrated start/done controller.
// Mode 0 adds M to R Q times; mode 1 is WIDTH-step shift-add.
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_bus,
    input  logic                 load_m,
    input  logic                 load_q,
    input  logic                 mode,
    input  logic                 start,
    input  logic                 out_en,
    output logic [2*WIDTH-1:0]   out_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 zero
);

    localparam int unsigned RW = 2 * WIDTH;

    state_e             state_q;
    logic               mode_q;
    logic [RW-1:0]      shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   q_q;
    logic [RW-1:0]      r_q;

    logic               m_load;
    logic               q_load;
    logic               q_dec;
    logic [WIDTH-1:0]   q_d;
    logic               r_clear;
    logic               r_load;
    logic [RW-1:0]      addend;
    logic [RW-1:0]      sum;
    logic [WIDTH-1:0]   m_new;
    logic               cnt_done;

    assign zero     = (q_q == '0);
    assign cnt_done = (cnt_q == CNT_W'(WIDTH));
    // Value M will hold after this edge, so a same-cycle load feeds the run.
    assign m_new    = load_m ? in_bus : m_q;

    // Register controls and adder operand selection per state and mode.
    always_comb begin
        m_load  = 1'b0;
        q_load  = 1'b0;
        q_dec   = 1'b0;
        q_d     = in_bus;
        r_clear = 1'b0;
        r_load  = 1'b0;
        addend  = (mode_q == MODE_SHIFTADD) ? shift_q : RW'(m_q);
        unique case (state_q)
            IDLE: begin
                m_load  = load_m;
                q_load  = load_q;
                r_clear = start;
            end
            RUN: begin
                if (mode_q == MODE_REPADD) begin
                    if (!zero) begin
                        r_load = 1'b1;
                        q_dec  = 1'b1;
                    end
                end else if (!cnt_done) begin
                    r_load = q_q[0];
                    q_load = 1'b1;
                    q_d    = q_q >> 1;
                end
            end
            default: ;
        endcase
    end

    // Carry-out beyond 2*WIDTH bits is dropped; a WIDTH x WIDTH product fits.
    assign sum = r_q + addend;

    gp_reg_n #(.W(WIDTH)) u_m (
        .clk(clk), .rst_n(rst_n), .load(m_load), .clear(1'b0),
        .dec(1'b0), .d(in_bus), .q(m_q)
    );

    gp_reg_n #(.W(WIDTH)) u_q (
        .clk(clk), .rst_n(rst_n), .load(q_load), .clear(1'b0),
        .dec(q_dec), .d(q_d), .q(q_q)
    );

    gp_reg_n #(.W(RW)) u_r (
        .clk(clk), .rst_n(rst_n), .load(r_load), .clear(r_clear),
        .dec(1'b0), .d(sum), .q(r_q)
    );

    // Controller: state, latched mode, shift register, counter, status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_REPADD;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        shift_q <= RW'(m_new);
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mode_q == MODE_REPADD) begin
                        if (zero) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (cnt_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign out_bus = out_en ? r_q : 'z;

endmodule
